knn_stream_driver: RTL and testbench
====================================

Name: knn_stream_driver

Overview:
- Host-side initiator for the KNN accelerator interface: buffers labelled training samples written by the host, then streams them one per cycle on the train_data/train_label/data_valid bus.
- Pulses training_done after the last sample, holds test data stable, waits for the accelerator's predicted_valid/predicted_label, and returns the result (or a timeout) to the host.
- Sits between the host register/DMA side and the accelerator top.

Parameters:
- DATA_WIDTH, 8, bits per feature.
- FEATURES, 8, features per sample.
- DEPTH, 16, training-sample buffer entries.
- ADDR_WIDTH, 4, buffer address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- TIMEOUT, 255, max WAIT cycles before the timeout error; range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en_i  in  1  host buffer write strobe.
- wr_addr_i  in  ADDR_WIDTH  buffer write address.
- wr_data_i  in  DATA_WIDTH*FEATURES  training sample.
- wr_label_i  in  1  training label.
- num_samples_i  in  ADDR_WIDTH+1  samples to stream; sampled on start.
- test_data_i  in  DATA_WIDTH*FEATURES  query vector; sampled on start.
- start_i  in  1  begin classification.
- train_data_o  out  DATA_WIDTH*FEATURES  to accelerator.
- train_label_o  out  1  to accelerator.
- data_valid_o  out  1  to accelerator.
- training_done_o  out  1  to accelerator.
- test_data_o  out  DATA_WIDTH*FEATURES  latched query, to accelerator.
- predicted_valid_i  in  1  from accelerator.
- predicted_label_i  in  1  from accelerator.
- busy_o  out  1  operation in progress.
- result_valid_o  out  1  one-cycle result pulse.
- result_label_o  out  1  last predicted label.
- timeout_o  out  1  one-cycle timeout pulse.

Behaviour:
- Clock/reset:
  - Single clock domain.
  - rst_n is asynchronous active-low.
  - Reset values: all outputs 0, FSM to IDLE, counters 0.
  - Buffer memory is not reset.
- FSM states: IDLE, STREAM, DONE, WAIT.
  - IDLE: start_i=1 latches test_data_i into test_data_o and N = min(num_samples_i, DEPTH), clears rd_ptr and result_label_o, sets busy_o.
  - IDLE exit: go to STREAM if N>0, else DONE.
  - STREAM: each cycle drives data_valid_o=1, train_data_o=mem[rd_ptr], train_label_o=label[rd_ptr], then increments rd_ptr. After N cycles go to DONE.
  - DONE: training_done_o=1 for exactly one cycle, data_valid_o=0, then go to WAIT.
  - WAIT: timeout counter increments each cycle.
    - predicted_valid_i=1: register predicted_label_i into result_label_o, pulse result_valid_o next cycle, go to IDLE.
    - Counter reaches TIMEOUT: pulse timeout_o, go to IDLE; result_valid_o is not asserted.
- Timing (start_i sampled high at edge T):
  - data_valid_o high during cycles T+1..T+N.
  - training_done_o high at T+N+1.
  - WAIT begins at T+N+2.
  - predicted_valid_i sampled at edge C -> result_valid_o high at cycle C+1.
  - busy_o high from T+1 through the cycle result_valid_o or timeout_o is high, inclusive.
- Output values outside STREAM:
  - data_valid_o=0 and train_label_o=0.
  - train_data_o holds its last value.
- Buffer writes:
  - Accepted only in IDLE, when wr_en_i=1 and wr_addr_i < DEPTH.
  - Writes while busy, or to addresses >= DEPTH, are dropped silently.
  - A write and start_i in the same IDLE cycle: the write lands first and is visible to the stream.
- Boundary conditions:
  - start_i while busy is ignored.
  - predicted_valid_i outside WAIT is ignored.
  - predicted_valid_i on the same cycle the timeout expires: the valid wins, and timeout_o is not asserted.
  - num_samples_i > DEPTH is clamped to DEPTH.
  - num_samples_i = 0: no data_valid_o, training_done_o at T+1.
  - rd_ptr never wraps; the stream ends at N.
  - test_data_o holds constant from T+1 until the next accepted start.
  - result_label_o holds until the next accepted start.
  - Reset mid-operation: all outputs drop to 0 immediately (asynchronous), FSM to IDLE; the next start behaves as after a fresh reset.
- Arithmetic: timeout counter width is 16 bits and saturates; no other arithmetic.

Test Plan:
- Basic stream: write 4 samples (0x0101..., 0x0202..., 0x0303..., 0x0404...; labels 1,0,1,0), start with N=4.
  - Required: data_valid_o high 4 cycles with data/labels in that order; training_done_o one pulse at T+5.
  - Then drive predicted_valid_i=1, predicted_label_i=1 -> result_valid_o pulse with result_label_o=1; busy_o falls.
- Zero samples: N=0 -> no data_valid_o; training_done_o at T+1; WAIT entered.
- Clamp and timeout: N=31, DEPTH=16, TIMEOUT=10, predicted_valid_i never asserted.
  - Required: exactly 16 data_valid_o cycles; timeout_o pulses 10 cycles into WAIT; no result_valid_o; busy_o clears.
- Protocol guards:
  - start_i and wr_en_i asserted during STREAM -> ignored; buffer unchanged on readback stream.
  - Spurious predicted_valid_i during STREAM -> no result.
- Race: predicted_valid_i arrives on the timeout-expiry cycle -> result_valid_o=1, timeout_o=0.
- Reset mid-STREAM: assert rst_n=0 after 2 samples -> outputs 0 asynchronously; then a new start with N=3 streams entries 0..2 correctly.

Source files
------------

// File: rtl/knn_stream_driver.sv
// Host-side initiator for the KNN accelerator: buffers labelled training samples,
// streams them one per cycle, then waits for the prediction or a timeout.
module knn_stream_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int FEATURES   = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH*FEATURES-1:0] wr_data_i,
    input  logic                           wr_label_i,
    input  logic [ADDR_WIDTH:0]            num_samples_i,
    input  logic [DATA_WIDTH*FEATURES-1:0] test_data_i,
    input  logic                           start_i,
    output logic [DATA_WIDTH*FEATURES-1:0] train_data_o,
    output logic                           train_label_o,
    output logic                           data_valid_o,
    output logic                           training_done_o,
    output logic [DATA_WIDTH*FEATURES-1:0] test_data_o,
    input  logic                           predicted_valid_i,
    input  logic                           predicted_label_i,
    output logic                           busy_o,
    output logic                           result_valid_o,
    output logic                           result_label_o,
    output logic                           timeout_o
);

    localparam int VW = DATA_WIDTH * FEATURES;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [15:0]         TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, STREAM, DONE, WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [15:0]           count_q, count_d;
    logic [VW-1:0]         test_data_q, test_data_d;
    logic [VW-1:0]         hold_data_q, hold_data_d;
    logic                  result_label_q, result_label_d;
    logic                  result_valid_q, result_valid_d;
    logic                  timeout_q, timeout_d;

    logic [VW-1:0]         mem [DEPTH];
    logic                  labels [DEPTH];

    logic                  idle_ready;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH:0]   n_clamped;

    // The pulse cycle after a result/timeout still counts as busy, so a start there is dropped.
    assign idle_ready = (state_q == IDLE) && !result_valid_q && !timeout_q;
    assign rd_idx     = rd_ptr_q[ADDR_WIDTH-1:0];
    assign n_clamped  = (num_samples_i > DEPTH_C) ? DEPTH_C : num_samples_i;

    always_ff @(posedge clk) begin
        if (idle_ready && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_C)) begin
            mem[wr_addr_i]    <= wr_data_i;
            labels[wr_addr_i] <= wr_label_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            n_q            <= '0;
            count_q        <= '0;
            test_data_q    <= '0;
            hold_data_q    <= '0;
            result_label_q <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            n_q            <= n_d;
            count_q        <= count_d;
            test_data_q    <= test_data_d;
            hold_data_q    <= hold_data_d;
            result_label_q <= result_label_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        n_d            = n_q;
        count_d        = count_q;
        test_data_d    = test_data_q;
        hold_data_d    = hold_data_q;
        result_label_d = result_label_q;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_ready && start_i) begin
                    test_data_d    = test_data_i;
                    n_d            = n_clamped;
                    rd_ptr_d       = '0;
                    count_d        = '0;
                    result_label_d = 1'b0;
                    state_d        = (n_clamped != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                // Remember the beat so train_data_o holds it once streaming stops.
                hold_data_d = mem[rd_idx];
                rd_ptr_d    = rd_ptr_q + 1'b1;
                if (rd_ptr_d == n_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                count_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (predicted_valid_i) begin
                    result_label_d = predicted_label_i;
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (count_d >= TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_valid_o    = (state_q == STREAM);
    assign train_data_o    = (state_q == STREAM) ? mem[rd_idx] : hold_data_q;
    assign train_label_o   = (state_q == STREAM) ? labels[rd_idx] : 1'b0;
    assign training_done_o = (state_q == DONE);
    assign test_data_o     = test_data_q;
    assign busy_o          = (state_q != IDLE) || result_valid_q || timeout_q;
    assign result_valid_o  = result_valid_q;
    assign result_label_o  = result_label_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_knn_stream_driver.sv
// Randomized bench for knn_stream_driver: a buffer model predicts the streamed beats
// and results; a negedge monitor pops the expected queues and compares.
module tb_knn_stream_driver;

    localparam int DATA_WIDTH = 8;
    localparam int FEATURES   = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int TIMEOUT    = 10;
    localparam int VW         = DATA_WIDTH * FEATURES;

    logic                  clk;
    logic                  rst_n;
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [VW-1:0]         wr_data_i;
    logic                  wr_label_i;
    logic [ADDR_WIDTH:0]   num_samples_i;
    logic [VW-1:0]         test_data_i;
    logic                  start_i;
    logic [VW-1:0]         train_data_o;
    logic                  train_label_o;
    logic                  data_valid_o;
    logic                  training_done_o;
    logic [VW-1:0]         test_data_o;
    logic                  predicted_valid_i;
    logic                  predicted_label_i;
    logic                  busy_o;
    logic                  result_valid_o;
    logic                  result_label_o;
    logic                  timeout_o;

    knn_stream_driver #(
        .DATA_WIDTH(DATA_WIDTH), .FEATURES(FEATURES), .DEPTH(DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_label_i(wr_label_i),
        .num_samples_i(num_samples_i), .test_data_i(test_data_i), .start_i(start_i),
        .train_data_o(train_data_o), .train_label_o(train_label_o), .data_valid_o(data_valid_o),
        .training_done_o(training_done_o), .test_data_o(test_data_o),
        .predicted_valid_i(predicted_valid_i), .predicted_label_i(predicted_label_i),
        .busy_o(busy_o), .result_valid_o(result_valid_o), .result_label_o(result_label_o),
        .timeout_o(timeout_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard state
    logic [VW-1:0] ref_mem [DEPTH];
    logic          ref_lab [DEPTH];
    logic [VW:0]   exp_q [$];
    logic [1:0]    res_q [$];
    logic [VW-1:0] last_data;
    logic [VW-1:0] exp_test;
    logic          exp_label;
    logic [VW:0]   e;
    logic [1:0]    r;
    int            n_cmp;
    int            n_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 128'({train_label_o, train_data_o}), 128'(e));
                    last_data = e[VW-1:0];
                end
            end else begin
                check("idle_label", 128'(train_label_o), 128'(0));
                check("idle_hold", 128'(train_data_o), 128'(last_data));
            end
            if (result_valid_o || timeout_o) begin
                if (res_q.size() == 0) begin
                    check("result_unexpected", 128'({timeout_o, result_valid_o}), 128'(0));
                end else begin
                    r = res_q.pop_front();
                    check("result", 128'({timeout_o, result_valid_o, result_label_o}),
                          128'({r[1], ~r[1], r[0]}));
                    exp_label = r[0];
                end
            end else if (!busy_o) begin
                check("label_hold", 128'(result_label_o), 128'(exp_label));
            end
            if (busy_o) begin
                check("test_hold", 128'(test_data_o), 128'(exp_test));
            end
        end
    end

    // driver tasks
    task automatic host_write(input int addr, input logic [VW-1:0] data, input logic lab);
        wr_en_i = 1'b1; wr_addr_i = 4'(addr); wr_data_i = data; wr_label_i = lab;
        if (addr < DEPTH) begin
            ref_mem[addr] = data;
            ref_lab[addr] = lab;
        end
        @(posedge clk); #1;
        wr_en_i = 1'b0;
    endtask

    // guard: 0 none, 1 start/write during stream, 2 spurious predicted_valid before WAIT
    task automatic run_op(input int num, input int guard, input int delay, input logic lab,
                          input logic cowrite);
        int n, cyc, w, ev, a;
        logic [VW-1:0] td;
        n  = (num > DEPTH) ? DEPTH : num;
        td = {$urandom, $urandom};
        start_i = 1'b1; num_samples_i = 5'(num); test_data_i = td;
        if (cowrite) begin
            a = $urandom_range(0, DEPTH - 1);
            wr_en_i = 1'b1; wr_addr_i = 4'(a); wr_data_i = {$urandom, $urandom};
            wr_label_i = 1'($urandom_range(0, 1));
            ref_mem[a] = wr_data_i;
            ref_lab[a] = wr_label_i;
        end
        exp_test = td;
        for (int i = 0; i < n; i++) exp_q.push_back({ref_lab[i], ref_mem[i]});
        @(posedge clk); #1;
        exp_label = 1'b0;
        start_i = 1'b0; wr_en_i = 1'b0;
        test_data_i = {$urandom, $urandom};
        num_samples_i = 5'($urandom_range(0, 31));
        cyc = 1;
        while (1) begin
            start_i = (guard == 1 && cyc <= 2);
            wr_en_i = start_i;
            wr_addr_i = 4'(cyc - 1);
            wr_data_i = {$urandom, $urandom};
            wr_label_i = 1'($urandom_range(0, 1));
            predicted_valid_i = (guard == 2);
            predicted_label_i = 1'b1;
            @(negedge clk);
            if (training_done_o || cyc >= 60) break;
            cyc++;
            @(posedge clk); #1;
        end
        start_i = 1'b0; wr_en_i = 1'b0; predicted_valid_i = 1'b0;
        check("done_time", 128'(cyc), 128'(n + 1));
        check("beats_all", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        res_q.push_back((delay < TIMEOUT) ? {1'b0, lab} : 2'b10);
        ev = (delay + 1 < TIMEOUT) ? delay + 1 : TIMEOUT;
        @(posedge clk); #1;
        w = 0;
        while (1) begin
            predicted_valid_i = (w == delay);
            predicted_label_i = lab;
            @(negedge clk);
            if (w == 0) check("done_pulse", 128'(training_done_o), 128'(0));
            if (result_valid_o || timeout_o || w >= 40) break;
            w++;
            @(posedge clk); #1;
        end
        predicted_valid_i = 1'b0;
        check("result_time", 128'(w), 128'(ev));
        check("busy_pulse", 128'(busy_o), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_end", 128'(busy_o), 128'(0));
        check("pulse_end", 128'({result_valid_o, timeout_o}), 128'(0));
        check("result_seen", 128'(res_q.size()), 128'(0));
        res_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        last_data = '0; exp_test = '0; exp_label = 1'b0;
        rst_n = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_label_i = 1'b0;
        num_samples_i = '0; test_data_i = '0; start_i = 1'b0;
        predicted_valid_i = 1'b0; predicted_label_i = 1'b0;

        #12;
        check("rst_valid", 128'(data_valid_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(training_done_o), 128'(0));
        check("rst_result", 128'({result_valid_o, result_label_o, timeout_o}), 128'(0));
        check("rst_train", 128'({train_label_o, train_data_o}), 128'(0));
        check("rst_test", 128'(test_data_o), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) host_write(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // basic stream
        host_write(0, {8{8'h01}}, 1'b1);
        host_write(1, {8{8'h02}}, 1'b0);
        host_write(2, {8{8'h03}}, 1'b1);
        host_write(3, {8{8'h04}}, 1'b0);
        run_op(4, 0, 3, 1'b1, 1'b0);
        // zero samples
        run_op(0, 0, 2, 1'b0, 1'b0);
        // clamp and timeout
        run_op(31, 0, 99, 1'b0, 1'b0);
        // start/write during stream, then readback
        run_op(5, 1, 1, 1'b1, 1'b0);
        run_op(5, 0, 0, 1'b0, 1'b0);
        // spurious predicted_valid before WAIT
        run_op(4, 2, 1, 1'b1, 1'b0);
        // valid on the timeout-expiry cycle
        run_op(3, 0, TIMEOUT - 1, 1'b1, 1'b0);
        // write in the same cycle as start
        run_op(2, 0, 4, 1'b1, 1'b1);

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 4)); j++)
                host_write($urandom_range(0, DEPTH - 1), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            run_op($urandom_range(0, 20), 0, $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        // reset in the middle of a stream
        for (int i = 0; i < 8; i++) host_write(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        start_i = 1'b1; num_samples_i = 5'd8; test_data_i = {$urandom, $urandom};
        exp_test = test_data_i;
        for (int i = 0; i < 8; i++) exp_q.push_back({ref_lab[i], ref_mem[i]});
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(data_valid_o), 128'(0));
        check("mid_rst_busy", 128'(busy_o), 128'(0));
        check("mid_rst_train", 128'({train_label_o, train_data_o}), 128'(0));
        check("mid_rst_test", 128'(test_data_o), 128'(0));
        check("mid_rst_beats", 128'(exp_q.size()), 128'(6));
        exp_q.delete();
        last_data = '0; exp_test = '0; exp_label = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3, 0, 2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
